alu_dec_pipe: RTL

Registered, parametrised successor of the single-cycle ALU decoder. It decodes the data-processing command field into ALU control, flag-write and no-write signals through one pipeline register with valid/stall/flush handling. It also owns the architectural NZCV flag register and evaluates the condition field, so flag updates are conditional and cycle-accurate. It sits between the main decoder (decode stage) and the ALU and register-file write-back (execute stage).

---
 rtl/alu_dec_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_dec_pipe.sv
// alu_dec_pipe
// Registered ALU command decoder with the architectural NZCV flag register.
// A data-processing command is decoded in the decode stage and captured in one
// execute-stage register. The condition field is evaluated in execute against
// the current flags, and that result gates the flag update.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready decode-stage handshake (in_ready = ~stall)
//   stall, flush      execute-stage hold / kill
//   ALUOp, Funct_cmd, Funct_s, Cond   decode-stage instruction fields
//   ALUFlags          NZCV produced by the ALU for the execute instruction
//   out_valid, ALUControl, FlagW, NoWrite, Illegal   registered decode
//   CondEx, FlagWrite combinational condition pass / gated flag write
//   Flags             NZCV register
module alu_dec_pipe #(
    parameter int          CTRL_W   = 3,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              ALUOp,
    input  logic [3:0]        Funct_cmd,
    input  logic              Funct_s,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    output logic              out_valid,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              NoWrite,
    output logic              Illegal,
    output logic              CondEx,
    output logic [1:0]        FlagWrite,
    output logic [3:0]        Flags
);

    localparam logic [3:0] COND_AL = 4'b1110;

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [1:0]        flag_w_q,  flag_w_d;
    logic              no_write_q, no_write_d;
    logic              illegal_q, illegal_d;
    logic [3:0]        cond_q,    cond_d;
    logic [3:0]        flags_q,   flags_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic [1:0]        dec_flag_w;
    logic              dec_no_write;
    logic              dec_illegal;

    logic [2:0] op_ctrl;
    logic       op_arith;
    logic       op_no_write;
    logic       op_legal;

    // Decode of the incoming command fields
    always_comb begin
        op_ctrl      = 3'b000;
        op_arith     = 1'b0;
        op_no_write  = 1'b0;
        op_legal     = 1'b1;
        dec_ctrl     = '0;
        dec_flag_w   = 2'b00;
        dec_no_write = 1'b0;
        dec_illegal  = 1'b0;
        case (Funct_cmd)
            4'b0100: begin op_ctrl = 3'b000; op_arith = 1'b1; end
            4'b0010: begin op_ctrl = 3'b001; op_arith = 1'b1; end
            4'b0000: begin op_ctrl = 3'b010; end
            4'b1100: begin op_ctrl = 3'b011; end
            4'b0001: begin op_ctrl = 3'b100; end
            4'b0011: begin op_ctrl = 3'b101; op_arith = 1'b1; end
            4'b1101: begin op_ctrl = 3'b110; end
            4'b1110: begin op_ctrl = 3'b111; end
            4'b1010: begin op_ctrl = 3'b001; op_arith = 1'b1; op_no_write = 1'b1; end
            4'b1011: begin op_ctrl = 3'b000; op_arith = 1'b1; op_no_write = 1'b1; end
            4'b1000: begin op_ctrl = 3'b010; op_no_write = 1'b1; end
            4'b1001: begin op_ctrl = 3'b100; op_no_write = 1'b1; end
            default: op_legal = 1'b0;
        endcase
        // compare/test commands exist only to set flags
        if (op_no_write && !Funct_s) begin
            op_legal = 1'b0;
        end
        if (ALUOp) begin
            if (op_legal) begin
                dec_ctrl[2:0] = op_ctrl;
                dec_flag_w    = Funct_s ? {1'b1, op_arith} : 2'b00;
                dec_no_write  = op_no_write;
            end else begin
                dec_no_write  = 1'b1;
                dec_illegal   = 1'b1;
            end
        end
    end

    // Condition evaluation against the architectural flags (N Z C V)
    always_comb begin
        CondEx = 1'b1;
        case (cond_q)
            4'b0000: CondEx =  flags_q[2];
            4'b0001: CondEx = ~flags_q[2];
            4'b0010: CondEx =  flags_q[1];
            4'b0011: CondEx = ~flags_q[1];
            4'b0100: CondEx =  flags_q[3];
            4'b0101: CondEx = ~flags_q[3];
            4'b0110: CondEx =  flags_q[0];
            4'b0111: CondEx = ~flags_q[0];
            4'b1000: CondEx =  flags_q[1] & ~flags_q[2];
            4'b1001: CondEx = ~flags_q[1] |  flags_q[2];
            4'b1010: CondEx =  (flags_q[3] == flags_q[0]);
            4'b1011: CondEx =  (flags_q[3] != flags_q[0]);
            4'b1100: CondEx = ~flags_q[2] &  (flags_q[3] == flags_q[0]);
            4'b1101: CondEx =  flags_q[2] |  (flags_q[3] != flags_q[0]);
            default: CondEx = 1'b1;
        endcase
    end

    assign FlagWrite = flag_w_q & {2{valid_q & CondEx & ~stall}};

    // Next state: flush > stall > load. Flags follow FlagWrite, which already
    // carries ~stall, so a flush without stall still retires the flag update.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        flag_w_d   = flag_w_q;
        no_write_d = no_write_q;
        illegal_d  = illegal_q;
        cond_d     = cond_q;
        flags_d    = flags_q;
        if (FlagWrite[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagWrite[0]) flags_d[1:0] = ALUFlags[1:0];
        if (flush || (!stall && !in_valid)) begin
            valid_d    = 1'b0;
            ctrl_d     = '0;
            flag_w_d   = 2'b00;
            no_write_d = 1'b0;
            illegal_d  = 1'b0;
            cond_d     = COND_AL;
        end else if (!stall) begin
            valid_d    = 1'b1;
            ctrl_d     = dec_ctrl;
            flag_w_d   = dec_flag_w;
            no_write_d = dec_no_write;
            illegal_d  = dec_illegal;
            cond_d     = Cond;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            flag_w_q   <= 2'b00;
            no_write_q <= 1'b0;
            illegal_q  <= 1'b0;
            cond_q     <= COND_AL;
            flags_q    <= FLAG_RST;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            flag_w_q   <= flag_w_d;
            no_write_q <= no_write_d;
            illegal_q  <= illegal_d;
            cond_q     <= cond_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready   = ~stall;
    assign out_valid  = valid_q;
    assign ALUControl = ctrl_q;
    assign FlagW      = flag_w_q;
    assign NoWrite    = no_write_q;
    assign Illegal    = illegal_q;
    assign Flags      = flags_q;

endmodule
